// File: rtl/data_mem_arbiter_if.sv
// Bundles the two master request/response channels and the data-memory port.
// slave modport is the arbiter side; master modport is the requester/memory side.
// Optional per-master access counters exist only when MEM_ARB_STATS_EN is defined.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

`ifdef MEM_ARB_STATS_EN
    logic [15:0]       m0_count;
    logic [15:0]       m1_count;
`endif

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
`ifdef MEM_ARB_STATS_EN
        , output m0_count, m1_count
`endif
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
`ifdef MEM_ARB_STATS_EN
        , input m0_count, m1_count
`endif
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter/sequencer for a single-port data memory, with bounded burst lock.
// Latency: gnt one cycle after req is sampled in IDLE, rvalid one cycle after gnt; one access per 2 cycles.
// Backpressure: a losing master simply keeps req high; optional counters under MEM_ARB_STATS_EN.
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    data_mem_arbiter_if.slave    bus
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              capture;
    logic              last_winner;
    logic [CNT_W-1:0]  burst_cnt;
    logic              win_id;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_lock;
    logic              any_req;

    logic              cap_id;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rdata0, rdata1;

    assign any_req   = bus.m0_req | bus.m1_req;
    assign last_lock = last_winner ? bus.m1_lock : bus.m0_lock;
    assign cnt_inc   = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + CNT_W'(1);

    // Winner selection: lock only matters under contention; otherwise alternate.
    always_comb begin
        win_id  = 1'b0;
        cnt_nxt = burst_cnt;
        if (bus.m0_req && bus.m1_req) begin
            if (last_lock && (burst_cnt < BURST_MAX)) begin
                win_id  = last_winner;
                cnt_nxt = burst_cnt + CNT_W'(1);
            end else begin
                win_id  = ~last_winner;
                cnt_nxt = '0;
            end
        end else if (bus.m1_req) begin
            win_id  = 1'b1;
            cnt_nxt = last_winner ? cnt_inc : '0;
        end else begin
            win_id  = 1'b0;
            cnt_nxt = last_winner ? '0 : cnt_inc;
        end
    end

    // Next state: capture in IDLE or RESP whenever anyone is requesting.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    capture   = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                if (any_req) begin
                    capture   = 1'b1;
                    state_nxt = ACCESS;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset discards any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Holding registers and arbitration history, loaded at each capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner <= 1'b1;
            burst_cnt   <= '0;
            cap_id      <= 1'b0;
            cap_we      <= 1'b0;
            cap_addr    <= '0;
            cap_wdata   <= '0;
        end else if (capture) begin
            last_winner <= win_id;
            burst_cnt   <= cnt_nxt;
            cap_id      <= win_id;
            cap_we      <= win_id ? bus.m1_we    : bus.m0_we;
            cap_addr    <= win_id ? bus.m1_addr  : bus.m0_addr;
            cap_wdata   <= win_id ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    // Read data is latched at the end of ACCESS; writes leave it untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == ACCESS && !cap_we) begin
            if (cap_id) rdata1 <= bus.mem_rd;
            else        rdata0 <= bus.mem_rd;
        end
    end

    assign bus.mem_we    = (state == ACCESS) && cap_we;
    assign bus.mem_a     = cap_addr;
    assign bus.mem_wd    = cap_wdata;
    assign bus.m0_gnt    = (state == ACCESS) && !cap_id;
    assign bus.m1_gnt    = (state == ACCESS) &&  cap_id;
    assign bus.m0_rvalid = (state == RESP)   && !cap_id;
    assign bus.m1_rvalid = (state == RESP)   &&  cap_id;
    assign bus.m0_rdata  = rdata0;
    assign bus.m1_rdata  = rdata1;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cnt0, cnt1;

    // Completed-access counters, saturating rather than wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (bus.m0_rvalid && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'd1;
            if (bus.m1_rvalid && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'd1;
        end
    end

    assign bus.m0_count = cnt0;
    assign bus.m1_count = cnt1;
`endif
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: table of single transactions plus
// hand-written contention, burst-lock and reset-during-access sequences.
module tb_data_mem_arbiter;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Behavioural 16-word memory, combinational read, word-indexed by byte address.
    logic [31:0] mem [0:15];
    assign bus.mem_rd = mem[bus.mem_a[5:2]];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a[5:2]] <= bus.mem_wd;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    // Starts mid-cycle with the DUT idle; returns mid-cycle with the DUT idle again.
    task automatic do_txn(input string tag, input logic m, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd);
        if (m) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
        @(negedge clk);
        check({tag, " gnt"},    {bus.m1_gnt, bus.m0_gnt}, m ? 2'b10 : 2'b01);
        check({tag, " rv_acc"}, {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
        check({tag, " mem_we"}, bus.mem_we, we);
        check({tag, " mem_a"},  bus.mem_a, addr);
        if (we) check({tag, " mem_wd"}, bus.mem_wd, wdata);
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        @(negedge clk);
        check({tag, " rvalid"},  {bus.m1_rvalid, bus.m0_rvalid}, m ? 2'b10 : 2'b01);
        check({tag, " gnt_rsp"}, {bus.m1_gnt, bus.m0_gnt}, 2'b00);
        check({tag, " we_rsp"},  bus.mem_we, 1'b0);
        check({tag, " rdata"},   m ? bus.m1_rdata : bus.m0_rdata, exp_rd);
        @(negedge clk);
        check({tag, " idle"}, {bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt}, 4'b0000);
    endtask

    initial begin
        int    ids [6];
        logic  id;
        logic [3:0] exp4;

        vecs[0] = '{m: 1'b0, we: 1'b0, addr: 32'h0000_0008, wdata: 32'h0,          exp_rdata: 32'hDEAD_BEEF};
        vecs[1] = '{m: 1'b1, we: 1'b1, addr: 32'h0000_0004, wdata: 32'h1234_5678, exp_rdata: 32'h0};
        vecs[2] = '{m: 1'b0, we: 1'b0, addr: 32'h0000_0004, wdata: 32'h0,          exp_rdata: 32'h1234_5678};
        vecs[3] = '{m: 1'b1, we: 1'b0, addr: 32'h0000_000B, wdata: 32'h0,          exp_rdata: 32'hDEAD_BEEF};
        vecs[4] = '{m: 1'b0, we: 1'b1, addr: 32'h0000_0010, wdata: 32'hCAFE_F00D, exp_rdata: 32'h1234_5678};
        vecs[5] = '{m: 1'b1, we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0,          exp_rdata: 32'hCAFE_F00D};

        for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | i;
        mem[2] <= 32'hDEAD_BEEF;

        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        reset_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst outs", {bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt, bus.mem_we}, 5'b0);
        check("rst mem_a", bus.mem_a, 32'h0);
        check("rst mem_wd", bus.mem_wd, 32'h0);
        check("rst rdata", {bus.m1_rdata, bus.m0_rdata}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single-master transactions
        for (int i = 0; i < 6; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].m, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rdata);
`ifdef MEM_ARB_STATS_EN
            if (i == 4) begin
                check("count0", bus.m0_count, 16'd3);
                check("count1", bus.m1_count, 16'd2);
            end
`endif
        end

        // Continuous contention, no lock: strict alternation starting with m0
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h8;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h10;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            case (k % 4)
                0: exp4 = 4'b0001;
                1: exp4 = 4'b0100;
                2: exp4 = 4'b0010;
                default: exp4 = 4'b1000;
            endcase
            check($sformatf("alt k%0d", k),
                  {bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt}, exp4);
            if (k % 4 == 1) check($sformatf("alt rd0 k%0d", k), bus.m0_rdata, 32'hDEAD_BEEF);
            if (k % 4 == 3) check($sformatf("alt rd1 k%0d", k), bus.m1_rdata, 32'hCAFE_F00D);
            if (k == 7) begin bus.m0_req = 1'b0; bus.m1_req = 1'b0; end
        end
        @(negedge clk);

        // Make m0 the last winner, then m1 bursts with lock against m0
        do_txn("prelock", 1'b0, 1'b0, 32'h8, 32'h0, 32'hDEAD_BEEF);
        ids = '{1, 1, 1, 1, 0, 1};
        bus.m0_req = 1'b1; bus.m1_req = 1'b1; bus.m1_lock = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            id = ids[k/2][0];
            if (k % 2 == 0) exp4 = id ? 4'b0010 : 4'b0001;
            else            exp4 = id ? 4'b1000 : 4'b0100;
            check($sformatf("lock k%0d", k),
                  {bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt}, exp4);
            check($sformatf("lock we k%0d", k), bus.mem_we, 1'b0);
            if (k == 11) begin bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.m1_lock = 1'b0; end
        end
        @(negedge clk);

        // Reset asserted during a write ACCESS
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h14; bus.m0_wdata = 32'h55AA_55AA;
        @(negedge clk);
        check("rstacc we_before", bus.mem_we, 1'b1);
        #1;
        reset_n    = 1'b0;
        bus.m0_req = 1'b0;
        bus.m0_we  = 1'b0;
        #1;
        check("rstacc we_drop", bus.mem_we, 1'b0);
        check("rstacc gnt_drop", {bus.m1_gnt, bus.m0_gnt}, 2'b00);
        @(negedge clk);
        check("rstacc no_rv", {bus.m1_rvalid, bus.m0_rvalid}, 2'b00);
        check("rstacc mem_kept", mem[5], 32'hA000_0005);
`ifdef MEM_ARB_STATS_EN
        check("rst count0", bus.m0_count, 16'd0);
        check("rst count1", bus.m1_count, 16'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        check("rstacc idle", {bus.m1_rvalid, bus.m0_rvalid, bus.m1_gnt, bus.m0_gnt}, 4'b0000);
        do_txn("postrst", 1'b0, 1'b0, 32'h14, 32'h0, 32'hA000_0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
